// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed 7-segment scan with blank dead-time and tear-free display updates.
// Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SHOW_CYC   = 1000,
   parameter int BLANK_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [3:0]              dec_d,
   output logic [NUM_DIGITS-1:0]   dig_an,
   output logic                    frame_done,
   output logic                    busy
);
   localparam int MAXC = SHOW_CYC > BLANK_CYC ? SHOW_CYC : BLANK_CYC;
   localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;
   localparam int IW   = $clog2(NUM_DIGITS);
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic [TW-1:0]           tmr, tmr_n;
   logic [4*NUM_DIGITS-1:0] shd_d, act_d, act_d_n;
   logic [NUM_DIGITS-1:0]   shd_m, act_m, act_m_n, sup, one_hot;
   logic                    pend, pend_n, last_blank, last_show, fd_now, upd;
   logic [3:0]              nib;
   always_comb begin
      last_blank = tmr == TW'(BLANK_CYC - 1);
      last_show  = tmr == TW'(SHOW_CYC - 1);
      fd_now     = state == SHOW && idx == IW'(NUM_DIGITS - 1) && last_show;
      upd        = fd_now || (state == IDLE && pend);
      // a load landing on the frame_done cycle bypasses the shadow so it is not lost
      act_d_n    = fd_now && load ? data_in : upd ? shd_d : act_d;
      act_m_n    = fd_now && load ? blank_mask : upd ? shd_m : act_m;
      pend_n     = load ? !fd_now : upd ? 1'b0 : pend;
   end
   always_comb begin
      state_n = state;
      idx_n   = idx;
      tmr_n   = tmr + 1'b1;
      case (state)
         IDLE: begin
            state_n = BLANK;
            idx_n   = '0;
            tmr_n   = '0;
         end
         BLANK: if (last_blank) begin
            state_n = SHOW;
            tmr_n   = '0;
         end
         default: if (last_show) begin
            state_n = BLANK;
            idx_n   = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            tmr_n   = '0;
         end
      endcase
      if (!en) begin
         state_n = IDLE;
         idx_n   = '0;
         tmr_n   = '0;
      end
   end
`ifdef SEVSEG_LZB_EN
   logic [NUM_DIGITS-1:0] lz;
   logic                  zero;
   always_comb begin
      lz   = '0;
      zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero  = zero && act_d_n[4*i +: 4] == 4'd0;
         lz[i] = zero;
      end
      sup = act_m_n | lz;
   end
`else
   always_comb sup = act_m_n;
`endif
   always_comb begin
      nib     = 4'(act_d_n >> {idx_n, 2'b00});
      one_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         tmr        <= '0;
         shd_d      <= '0;
         shd_m      <= '0;
         act_d      <= '0;
         act_m      <= '0;
         pend       <= 1'b0;
         dec_d      <= '0;
         dig_an     <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         tmr        <= tmr_n;
         shd_d      <= load ? data_in : shd_d;
         shd_m      <= load ? blank_mask : shd_m;
         act_d      <= act_d_n;
         act_m      <= act_m_n;
         pend       <= pend_n;
         // outputs are registered from next-state values so they line up with the state they describe
         dec_d      <= state_n == IDLE ? 4'd0 : nib;
         dig_an     <= state_n == SHOW && !(|(sup & one_hot)) ? one_hot : '0;
         frame_done <= state_n == SHOW && idx_n == IW'(NUM_DIGITS - 1) && tmr_n == TW'(SHOW_CYC - 1);
         busy       <= state_n != IDLE;
      end
   end
endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares a single BCD/hex-to-7-segment decoder among NUM_DIGITS common-anode/cathode digit positions. It holds a shadow and an active digit register, steps through the digits with a dead-time (blank) interval between them to prevent ghosting, and drives the 4-bit decoder input plus the one-hot digit-enable lines. It sits between the register/CPU side that loads display values and the decoder/pin driver.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
SHOW_CYC, 1000, clock cycles each digit is lit; must be >= 1.
BLANK_CYC, 2, dead-time cycles before each digit with all enables off; must be >= 1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  scan enable; low forces IDLE.
load  in  1  one-cycle strobe; captures data_in and blank_mask into the shadow registers.
data_in  in  4*NUM_DIGITS  digit values; digit i = bits [4i+3:4i]; digit 0 is least significant.
blank_mask  in  NUM_DIGITS  1 = digit i is never lit.
dec_d  out  4  nibble to the shared 7-segment decoder.
dig_an  out  NUM_DIGITS  active-high one-hot digit enables.
frame_done  out  1  one-cycle pulse on the last SHOW cycle of the last digit.
busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. Reset (rst=1 at an edge) sets state=IDLE, idx=0, the timer to 0, shadow/active data and masks to 0, the pending flag to 0, and dec_d, dig_an, frame_done and busy to 0. Reset overrides every other input, including in mid-frame.
- States:
  - IDLE: dig_an=0, dec_d=0.
  - BLANK: dig_an=0; dec_d = active nibble[idx].
  - SHOW: dig_an[idx]=1 unless the digit is masked; dec_d = active nibble[idx].
- Transitions:
  - IDLE -> BLANK(idx=0) on the edge where en=1.
  - BLANK -> SHOW after exactly BLANK_CYC cycles.
  - SHOW -> BLANK(idx+1) after exactly SHOW_CYC cycles.
  - idx wraps from NUM_DIGITS-1 to 0.
  - Any state -> IDLE on the edge where en=0. idx and the timer clear, and dig_an is 0 in the following cycle.
- Frame length: NUM_DIGITS*(BLANK_CYC+SHOW_CYC) cycles; the scan is continuous while en=1.
- Masked digit: the timing slots are unchanged, but dig_an stays all-zero during that digit's SHOW.
- Load and tearing rules:
  - load copies data_in and blank_mask into shadow and sets pending.
  - The active copy is updated from shadow only at the edge that ends the frame_done cycle, or on the next edge if the state is IDLE. pending then clears.
  - If load coincides with the frame_done cycle, the newly loaded value (not the older shadow) becomes active at that same edge.
  - Back-to-back loads: the last one wins.
- frame_done is high only while state=SHOW, idx=NUM_DIGITS-1 and the timer is on its final count. It is never high in IDLE.
- Timers are sized to $clog2 of the larger of SHOW_CYC and BLANK_CYC. idx is sized to $clog2(NUM_DIGITS) with a minimum of 1 bit. No other arithmetic is performed.

Optional Feature:
SEVSEG_LZB_EN: when defined, leading-zero blanking is applied. Digit i (i >= 1) is also suppressed during SHOW when active nibble i and every higher nibble are 0. Digit 0 is never suppressed by this rule. The suppression is ORed with blank_mask and evaluated on the active data only. When the macro is undefined, only blank_mask suppresses digits. Timing is identical in both builds.

Test Plan:
All scenarios use NUM_DIGITS=4, SHOW_CYC=4, BLANK_CYC=1 (frame = 20 cycles).
1. Reset, then load data_in=16'h4321 and mask=0, then en=1 -> BLANK 1 cycle with dig_an=0000 and dec_d=1; SHOW 4 cycles with dig_an=0001 and dec_d=1; then dec_d=2/0010, 3/0100, 4/1000. frame_done fires on cycle 20 only, and the pattern repeats.
2. Mid-frame load of 16'h8765 during digit 1 -> the digit 2/3 slots still show 3/4; the next frame shows 5,6,7,8. A load in the frame_done cycle takes effect at the next frame.
3. blank_mask=4'b0100 with 16'h4321 -> the digit-2 SHOW slot has dig_an=0000 for 4 cycles with dec_d=3; the other slots are normal and the frame is still 20 cycles.
4. en dropped during the digit-1 SHOW -> next cycle dig_an=0, dec_d=0, busy=0. Re-raising en restarts at BLANK idx=0.
5. rst asserted mid-SHOW -> next cycle all outputs are 0 and the active data is 0. After en=1 with no load, dec_d=0 on all digits.
6. With SEVSEG_LZB_EN defined, data 16'h0070 -> digits 3 and 2 are dark, digit 1 shows 7 and digit 0 shows 0. Data 16'h0000 -> only digit 0 is lit. Without the macro, all four digits are lit.
